mac_jtag_wrapper: RTL and testbench

Combinational multiply-accumulate core (z = a*b + c) wrapped with an IEEE 1149.1-style JTAG TAP, a 32-bit IDCODE register, a BYPASS register and a boundary-scan register over all core I/O. Used as the top-level DFT wrapper around the MAC datapath. In functional mode the core path is transparent. Under EXTEST the core I/O is controlled and observed through the scan chain.

---
 rtl/mac_jtag_pkg.sv | 53 +++++
 rtl/mac_jtag_if.sv | 15 +
 rtl/jtag_tap_fsm.sv | 57 +++++
 rtl/mac_jtag_wrapper.sv | 154 +++++++++++++++
 tb/tb_mac_jtag_wrapper.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_jtag_pkg.sv
// Shared types and constants for the MAC core JTAG wrapper: TAP states, opcodes,
// widths, and the TAP next-state function.
package mac_jtag_pkg;

  localparam logic [31:0] IDCODE_DEFAULT = 32'hF00ED093;
  localparam int IR_W    = 4;
  localparam int AB_W    = 8;
  localparam int Z_W     = 24;
  localparam int BSR_LEN = 64;

  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;
  localparam logic [IR_W-1:0] OP_EXTEST  = 4'b0000;
  localparam logic [IR_W-1:0] OP_IDCODE  = 4'b0001;
  localparam logic [IR_W-1:0] OP_SAMPLE  = 4'b0010;
  localparam logic [IR_W-1:0] OP_BYPASS  = 4'b1111;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSR    = 2'd2
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mac_jtag_if.sv
// Test-port and MAC data signals of the wrapper; master drives stimulus, slave is the wrapper.
interface mac_jtag_if;
  import mac_jtag_pkg::*;

  logic            TMS;
  logic            TDI;
  logic            TDO;
  logic [AB_W-1:0] a;
  logic [AB_W-1:0] b;
  logic [Z_W-1:0]  c;
  logic [Z_W-1:0]  z;

  modport master (output TMS, TDI, a, b, c, input TDO, z);
  modport slave  (input TMS, TDI, a, b, c, output TDO, z);
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register, instruction register and registered
// per-state strobes (each strobe is high while the TAP sits in that state).
module jtag_tap_fsm
  import mac_jtag_pkg::*;
(
  input  logic            tck,
  input  logic            reset,
  input  logic            tms,
  input  logic            tdi,
  output logic [IR_W-1:0] ir_r,
  output logic            ir_lsb_s,
  output logic            tlr_r,
  output logic            capture_dr_r,
  output logic            shift_dr_r,
  output logic            update_dr_r,
  output logic            shift_ir_r
);

  tap_state_e      state_r;
  tap_state_e      nxt_s;
  logic [IR_W-1:0] ir_sr_r;

  assign nxt_s    = tap_next(state_r, tms);
  assign ir_lsb_s = ir_sr_r[0];

  // TAP state walk, strobe registers and IR capture/shift/update
  always_ff @(posedge tck) begin
    if (reset) begin
      state_r      <= TLR;
      ir_r         <= OP_IDCODE;
      ir_sr_r      <= IR_CAPTURE;
      tlr_r        <= 1'b1;
      capture_dr_r <= 1'b0;
      shift_dr_r   <= 1'b0;
      update_dr_r  <= 1'b0;
      shift_ir_r   <= 1'b0;
    end else begin
      state_r      <= nxt_s;
      tlr_r        <= (nxt_s == TLR);
      capture_dr_r <= (nxt_s == CAP_DR);
      shift_dr_r   <= (nxt_s == SHIFT_DR);
      update_dr_r  <= (nxt_s == UPD_DR);
      shift_ir_r   <= (nxt_s == SHIFT_IR);
      if (state_r == TLR) begin
        ir_r <= OP_IDCODE;
      end else if (state_r == UPD_IR) begin
        ir_r <= ir_sr_r;
      end
      if (state_r == CAP_IR) begin
        ir_sr_r <= IR_CAPTURE;
      end else if (state_r == SHIFT_IR) begin
        ir_sr_r <= {tdi, ir_sr_r[IR_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/mac_jtag_wrapper.sv
// MAC core (z = a*b + c mod 2^24) behind a JTAG TAP with IDCODE, BYPASS and,
// when BSCAN_EN is defined, a 64-cell boundary register with SAMPLE/PRELOAD and EXTEST.
module mac_jtag_wrapper
  import mac_jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = IDCODE_DEFAULT
) (
  input logic       TCK,
  input logic       reset,
  mac_jtag_if.slave jif
);

  logic [IR_W-1:0] ir_s;
  logic            ir_lsb_s;
  logic            tlr_s;
  logic            capture_dr_s;
  logic            shift_dr_s;
  logic            update_dr_s;
  logic            shift_ir_s;
  dr_sel_e         dr_sel_s;
  logic [31:0]     idcode_sr_r;
  logic            bypass_r;
  logic            bsr_lsb_s;
  logic            dr_lsb_s;
  logic            tdo_r;
  logic [AB_W-1:0] core_a_s;
  logic [AB_W-1:0] core_b_s;
  logic [Z_W-1:0]  core_c_s;
  logic [Z_W-1:0]  core_z_s;

  function automatic dr_sel_e decode_dr(input logic [IR_W-1:0] ir);
    dr_sel_e sel;
    case (ir)
      OP_IDCODE: sel = DR_IDCODE;
`ifdef BSCAN_EN
      OP_EXTEST, OP_SAMPLE: sel = DR_BSR;
`endif
      default:   sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

  jtag_tap_fsm u_tap (
    .tck          (TCK),
    .reset        (reset),
    .tms          (jif.TMS),
    .tdi          (jif.TDI),
    .ir_r         (ir_s),
    .ir_lsb_s     (ir_lsb_s),
    .tlr_r        (tlr_s),
    .capture_dr_r (capture_dr_s),
    .shift_dr_r   (shift_dr_s),
    .update_dr_r  (update_dr_s),
    .shift_ir_r   (shift_ir_s)
  );

  assign dr_sel_s = decode_dr(ir_s);
  assign core_z_s = Z_W'(core_a_s) * Z_W'(core_b_s) + core_c_s;

  // IDCODE and BYPASS data registers
  always_ff @(posedge TCK) begin
    if (reset) begin
      idcode_sr_r <= IDCODE;
      bypass_r    <= 1'b0;
    end else begin
      if (capture_dr_s && dr_sel_s == DR_IDCODE) begin
        idcode_sr_r <= IDCODE;
      end else if (shift_dr_s && dr_sel_s == DR_IDCODE) begin
        idcode_sr_r <= {jif.TDI, idcode_sr_r[31:1]};
      end
      if (capture_dr_s && dr_sel_s == DR_BYPASS) begin
        bypass_r <= 1'b0;
      end else if (shift_dr_s && dr_sel_s == DR_BYPASS) begin
        bypass_r <= jif.TDI;
      end
    end
  end

`ifdef BSCAN_EN
  logic [BSR_LEN-1:0] bsr_r;
  logic [BSR_LEN-1:0] bupd_r;
  logic               extest_s;

  assign extest_s  = (ir_s == OP_EXTEST);
  assign bsr_lsb_s = bsr_r[0];

  // Boundary capture/shift chain and its update latch (cleared in Test-Logic-Reset)
  always_ff @(posedge TCK) begin
    if (reset) begin
      bsr_r  <= {BSR_LEN{1'b0}};
      bupd_r <= {BSR_LEN{1'b0}};
    end else begin
      if (capture_dr_s && dr_sel_s == DR_BSR) begin
        bsr_r <= {core_z_s, jif.c, jif.b, jif.a};
      end else if (shift_dr_s && dr_sel_s == DR_BSR) begin
        bsr_r <= {jif.TDI, bsr_r[BSR_LEN-1:1]};
      end
      if (tlr_s) begin
        bupd_r <= {BSR_LEN{1'b0}};
      end else if (update_dr_s && dr_sel_s == DR_BSR) begin
        bupd_r <= bsr_r;
      end
    end
  end

  // Under EXTEST the core and the z pins are isolated from the functional pins
  always_comb begin
    core_a_s = jif.a;
    core_b_s = jif.b;
    core_c_s = jif.c;
    jif.z    = core_z_s;
    if (extest_s) begin
      core_a_s = bupd_r[7:0];
      core_b_s = bupd_r[15:8];
      core_c_s = bupd_r[39:16];
      jif.z    = bupd_r[63:40];
    end else begin
      jif.z    = core_z_s;
    end
  end
`else
  logic unused_bscan_s;

  assign unused_bscan_s = tlr_s ^ update_dr_s;
  assign bsr_lsb_s      = 1'b0;
  assign core_a_s       = jif.a;
  assign core_b_s       = jif.b;
  assign core_c_s       = jif.c;
  assign jif.z          = core_z_s;
`endif

  // Serial output of the selected data register
  always_comb begin
    case (dr_sel_s)
      DR_IDCODE: dr_lsb_s = idcode_sr_r[0];
      DR_BSR:    dr_lsb_s = bsr_lsb_s;
      default:   dr_lsb_s = bypass_r;
    endcase
  end

  // TDO changes on the falling edge so it is stable at the next rising edge
  always_ff @(negedge TCK) begin
    if (shift_dr_s) begin
      tdo_r <= dr_lsb_s;
    end else if (shift_ir_s) begin
      tdo_r <= ir_lsb_s;
    end else begin
      tdo_r <= 1'b0;
    end
  end

  assign jif.TDO = tdo_r;

endmodule

// File: tb/tb_mac_jtag_wrapper.sv
// Self-checking bench for mac_jtag_wrapper: core vector table plus JTAG scan sequences
// scored through an expected-value queue.
module tb_mac_jtag_wrapper;
  import mac_jtag_pkg::*;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [23:0] c;
    logic [23:0] z;
  } core_vec_t;

  logic        TCK = 1'b0;
  logic        reset;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cap;
  logic        dmy;
  core_vec_t   vecs[6];

  mac_jtag_if jif();

  mac_jtag_wrapper dut (
    .TCK   (TCK),
    .reset (reset),
    .jif   (jif)
  );

  always #5 TCK = ~TCK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_pop(input string name, input logic [63:0] act);
    logic [63:0] exp_v;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %h but no expected value queued", name, act);
    end else begin
      exp_v = exp_q.pop_front();
      if (act === exp_v) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // One TCK cycle; TDO sampled just before the rising edge
  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    jif.TMS = tms_v;
    jif.TDI = tdi_v;
    tdo_v   = jif.TDO;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic tms_seq(input int n, input logic [7:0] bits);
    logic d;
    for (int i = 0; i < n; i++) step(bits[i], 1'b0, d);
  endtask

  task automatic shift(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic t;
    dout = 64'h0;
    for (int i = 0; i < n; i++) begin
      step((i == n - 1), din[i], t);
      dout[i] = t;
    end
  endtask

  // Starts and ends in Run-Test/Idle
  task automatic scan_ir(input logic [3:0] op, output logic [63:0] c_out);
    tms_seq(4, 8'b0000_0011);
    shift(4, {60'h0, op}, c_out);
    tms_seq(2, 8'b0000_0001);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] c_out);
    tms_seq(3, 8'b0000_0001);
    shift(n, din, c_out);
    tms_seq(2, 8'b0000_0001);
  endtask

  task automatic set_pins(input logic [7:0] av, input logic [7:0] bv, input logic [23:0] cv);
    jif.a = av;
    jif.b = bv;
    jif.c = cv;
    #1;
  endtask

  initial begin
    vecs[0] = '{a: 8'd10,  b: 8'd7,   c: 24'd1,       z: 24'd71};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 24'hFFFFFF,  z: 24'h00FE00};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   c: 24'h000000,  z: 24'h000000};
    vecs[3] = '{a: 8'd1,   b: 8'd1,   c: 24'h000000,  z: 24'h000001};
    vecs[4] = '{a: 8'd200, b: 8'd3,   c: 24'h000100,  z: 24'h000358};
    vecs[5] = '{a: 8'h80,  b: 8'd2,   c: 24'hFFFF00,  z: 24'h000000};

    jif.TMS = 1'b1;
    jif.TDI = 1'b0;
    set_pins(8'd10, 8'd7, 24'd1);
    reset = 1'b1;
    @(negedge TCK);
    #1;
    step(1'b1, 1'b0, dmy);
    step(1'b1, 1'b0, dmy);
    reset = 1'b0;

    push_exp(64'h0);
    check_pop("tdo_after_reset", {63'h0, jif.TDO});
    push_exp(64'd71);
    check_pop("z_after_reset", 64'(jif.z));

    // IDCODE readout, then pause and re-enter Shift-DR to read back what was shifted in
    tms_seq(5, 8'b0001_1111);
    tms_seq(4, 8'b0000_0010);
    push_exp(64'hF00ED093);
    shift(32, 64'h7F, cap);
    check_pop("idcode_read", cap);
    tms_seq(3, 8'b0000_0010);
    push_exp(64'h7F);
    shift(32, 64'h0, cap);
    check_pop("idcode_shift_through", cap);
    tms_seq(2, 8'b0000_0001);

    // Functional core from Test-Logic-Reset
    tms_seq(5, 8'b0001_1111);
    for (int i = 0; i < 6; i++) begin
      set_pins(vecs[i].a, vecs[i].b, vecs[i].c);
      push_exp(64'(vecs[i].z));
      check_pop($sformatf("core_vec%0d", i), 64'(jif.z));
    end
    tms_seq(1, 8'b0000_0000);

    // BYPASS: capture of IR shifts out 0001, DR is a one-cycle delay starting with 0
    push_exp(64'h1);
    scan_ir(OP_BYPASS, cap);
    check_pop("ir_capture_bypass", cap);
    push_exp(64'hA);
    scan_dr(4, 64'hD, cap);
    check_pop("bypass_1011", cap);
    push_exp(64'h4A);
    scan_dr(8, 64'hA5, cap);
    check_pop("bypass_a5", cap);

    // Undefined opcode behaves as BYPASS
    push_exp(64'h1);
    scan_ir(4'b0110, cap);
    check_pop("ir_capture_0110", cap);
    push_exp(64'h78);
    scan_dr(8, 64'h3C, cap);
    check_pop("undef_op_bypass", cap);

    // Abandon a DR shift with five TMS=1 cycles; IR must fall back to IDCODE
    tms_seq(3, 8'b0000_0001);
    step(1'b0, 1'b1, dmy);
    step(1'b0, 1'b0, dmy);
    step(1'b0, 1'b1, dmy);
    tms_seq(5, 8'b0001_1111);
    tms_seq(1, 8'b0000_0000);
    push_exp(64'hF00ED093);
    scan_dr(32, 64'h0, cap);
    check_pop("idcode_after_tms_reset", cap);

    set_pins(8'd10, 8'd7, 24'd1);
`ifdef BSCAN_EN
    push_exp(64'h1);
    scan_ir(OP_SAMPLE, cap);
    check_pop("ir_capture_sample", cap);
    push_exp({24'd71, 24'd1, 8'd7, 8'd10});
    scan_dr(64, 64'h0, cap);
    check_pop("sample_capture", cap);
    push_exp({24'd71, 24'd1, 8'd7, 8'd10});
    scan_dr(64, {24'hABCDEF, 24'd5, 8'd4, 8'd3}, cap);
    check_pop("preload_capture", cap);
    push_exp(64'd71);
    check_pop("z_during_sample", 64'(jif.z));

    scan_ir(OP_EXTEST, cap);
    push_exp(64'hABCDEF);
    check_pop("extest_z_pin", 64'(jif.z));
    set_pins(8'd200, 8'd7, 24'd1);
    push_exp(64'hABCDEF);
    check_pop("extest_pins_isolated", 64'(jif.z));
    push_exp({24'd17, 24'd1, 8'd7, 8'd200});
    scan_dr(64, {24'hABCDEF, 24'd5, 8'd4, 8'd3}, cap);
    check_pop("extest_capture", cap);
    push_exp(64'hABCDEF);
    check_pop("extest_z_after_update", 64'(jif.z));
`else
    push_exp(64'hA);
    scan_ir(OP_SAMPLE, cap);
    scan_dr(4, 64'hD, cap);
    check_pop("sample_as_bypass", cap);
    push_exp(64'h4A);
    scan_ir(OP_EXTEST, cap);
    scan_dr(8, 64'hA5, cap);
    check_pop("extest_as_bypass", cap);
    set_pins(8'd200, 8'd7, 24'd1);
    push_exp(64'd1401);
    check_pop("z_functional_extest_op", 64'(jif.z));
`endif

    // Reset in the middle of a DR shift returns z to the functional result
    tms_seq(3, 8'b0000_0001);
    step(1'b0, 1'b1, dmy);
    step(1'b0, 1'b0, dmy);
    reset = 1'b1;
    step(1'b0, 1'b0, dmy);
    reset = 1'b0;
    push_exp(64'd1401);
    check_pop("z_after_mid_reset", 64'(jif.z));
    push_exp(64'h0);
    check_pop("tdo_after_mid_reset", {63'h0, jif.TDO});
    tms_seq(1, 8'b0000_0000);
    push_exp(64'hF00ED093);
    scan_dr(32, 64'h0, cap);
    check_pop("idcode_after_mid_reset", cap);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
